pifo_calendar_queue: RTL and testbench

Parametrised calendar PIFO: a DEPTH-entry sorted shift array that always keeps its most significant element at the head. It supports single-cycle insert, pop, insert+pop, overflow-bit wrap-around ordering, occupancy tracking and explicit drop reporting when full. It sits between the scheduler's rank computation and the egress dequeue logic, and replaces hand-instantiated rows of single atoms.

---
 rtl/pifo_calendar_pkg.sv | 50 +++++
 rtl/pifo_calendar_queue_cell.sv | 63 ++++++
 rtl/pifo_calendar_queue.sv | 146 ++++++++++++++
 tb/tb_pifo_calendar_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_calendar_pkg.sv
// Calendar PIFO shared types: element layout, cell modes, significance test.
// Imported by the queue, its cells and scoreboards.
package pifo_calendar_pkg;

  localparam int ELEM_RANK_W = 18;
  localparam int ELEM_ADDR_W = 12;
  localparam int VALID_POS   = 1 + ELEM_RANK_W + ELEM_ADDR_W;
  localparam int OVF_POS     = ELEM_RANK_W + ELEM_ADDR_W;
  localparam int RANK_LSB    = ELEM_ADDR_W;

  typedef struct packed {
    logic                   valid;
    logic                   ovf;
    logic [ELEM_RANK_W-1:0] rank;
    logic [ELEM_ADDR_W-1:0] addr;
  } pifo_elem_t;

  typedef enum logic [2:0] {
    M_HOLD,
    M_INS,
    M_POP,
    M_INSPOP,
    M_FLUSH
  } pifo_mode_t;

  // Ranks are zero-extended so one function serves any RANK_W <= 64.
  typedef logic [63:0] rank_t;

  // A beats B. A is always a valid element.
  function automatic logic beats(
    input logic  a_ovf,
    input rank_t a_rank,
    input logic  b_valid,
    input logic  b_ovf,
    input rank_t b_rank,
    input logic  g_ovf
  );
    logic r;
    if (!b_valid)
      r = 1'b1;
    else if (a_ovf == g_ovf && b_ovf != g_ovf)
      r = 1'b1;
    else if (a_ovf != g_ovf && b_ovf == g_ovf)
      r = 1'b0;
    else
      r = (a_rank < b_rank);
    return r;
  endfunction

endpackage

// File: rtl/pifo_calendar_queue_cell.sv
// One PIFO slot: element register, beat bit against the input element,
// and the hold/input/left/right next-state mux.
module pifo_calendar_cell
  import pifo_calendar_pkg::*;
#(
  parameter int RANK_W = ELEM_RANK_W,
  parameter int ADDR_W = ELEM_ADDR_W,
  parameter bit FIRST  = 1'b0,
  localparam int W     = 2 + RANK_W + ADDR_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  pifo_mode_t   mode,
  input  logic         g_ovf,
  input  logic [W-1:0] in_elem,
  input  logic [W-1:0] prev_elem,
  input  logic [W-1:0] next_elem,
  input  logic         beat_prev,
  input  logic         beat_next,
  output logic [W-1:0] elem,
  output logic         beat
);

  logic [W-1:0] nxt;

  assign beat = beats(in_elem[W-2],
                      rank_t'(in_elem[W-3:ADDR_W]),
                      elem[W-1],
                      elem[W-2],
                      rank_t'(elem[W-3:ADDR_W]),
                      g_ovf);

  always_comb begin
    nxt = elem;
    unique case (mode)
      M_FLUSH: nxt = '0;
      M_INS: begin
        if (beat && !beat_prev)
          nxt = in_elem;
        else if (beat && beat_prev)
          nxt = prev_elem;
      end
      M_POP: nxt = next_elem;
      M_INSPOP: begin
        // The head slot is being vacated, so it takes the
        // input even when the input also beats it.
        if (!beat_next)
          nxt = next_elem;
        else if (!beat || FIRST)
          nxt = in_elem;
      end
      default: nxt = elem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      elem <= '0;
    else
      elem <= nxt;
  end

endmodule

// File: rtl/pifo_calendar_queue.sv
// Calendar PIFO: DEPTH sorted slots, head at slot 0, with insert, pop,
// insert+pop, epoch wrap, occupancy and drop reporting.
module pifo_calendar_queue
  import pifo_calendar_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int RANK_W = ELEM_RANK_W,
  parameter int ADDR_W = ELEM_ADDR_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int W     = 2 + RANK_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_flush,
  input  logic              in_ins_valid,
  input  logic              in_ins_ovf,
  input  logic [RANK_W-1:0] in_ins_rank,
  input  logic [ADDR_W-1:0] in_ins_addr,
  input  logic              in_pop,
  output logic              out_pop_valid,
  output logic              out_pop_ovf,
  output logic [RANK_W-1:0] out_pop_rank,
  output logic [ADDR_W-1:0] out_pop_addr,
  output logic              out_drop_valid,
  output logic [ADDR_W-1:0] out_drop_addr,
  output logic [W-1:0]      out_head,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_empty,
  output logic              out_full,
  output logic              out_global_ovf
);

  logic [W-1:0]     slot [DEPTH];
  logic             beat [DEPTH];
  logic [W-1:0]     in_elem;
  logic [CNT_W-1:0] count;
  logic             g_ovf;
  logic             empty;
  logic             full;
  logic             pop_fire;
  pifo_mode_t       mode;

  assign in_elem  = {1'b1, in_ins_ovf, in_ins_rank, in_ins_addr};
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_fire = in_pop && !empty;

  always_comb begin
    mode = M_HOLD;
    if (in_flush)
      mode = M_FLUSH;
    else if (in_ins_valid && pop_fire)
      mode = M_INSPOP;
    else if (in_ins_valid && !(full && !beat[DEPTH-1]))
      mode = M_INS;
    else if (pop_fire)
      mode = M_POP;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [W-1:0] prev_e;
    logic [W-1:0] next_e;
    logic         bp;
    logic         bn;

    if (i == 0) begin : g_first
      assign prev_e = '0;
      assign bp     = 1'b0;
    end else begin : g_mid_l
      assign prev_e = slot[i-1];
      assign bp     = beat[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign next_e = '0;
      assign bn     = 1'b1;
    end else begin : g_mid_r
      assign next_e = slot[i+1];
      assign bn     = beat[i+1];
    end

    pifo_calendar_cell #(
      .RANK_W (RANK_W),
      .ADDR_W (ADDR_W),
      .FIRST  (i == 0)
    ) u_cell (
      .clk       (clk),
      .rstn      (rstn),
      .mode      (mode),
      .g_ovf     (g_ovf),
      .in_elem   (in_elem),
      .prev_elem (prev_e),
      .next_elem (next_e),
      .beat_prev (bp),
      .beat_next (bn),
      .elem      (slot[i]),
      .beat      (beat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count          <= '0;
      g_ovf          <= 1'b0;
      out_pop_valid  <= 1'b0;
      out_pop_ovf    <= 1'b0;
      out_pop_rank   <= '0;
      out_pop_addr   <= '0;
      out_drop_valid <= 1'b0;
      out_drop_addr  <= '0;
    end else begin
      out_pop_valid  <= 1'b0;
      out_drop_valid <= 1'b0;
      if (in_flush) begin
        count <= '0;
      end else begin
        if (pop_fire) begin
          out_pop_valid <= 1'b1;
          out_pop_ovf   <= slot[0][W-2];
          out_pop_rank  <= slot[0][W-3:ADDR_W];
          out_pop_addr  <= slot[0][ADDR_W-1:0];
          g_ovf         <= slot[0][W-2];
        end
        if (in_ins_valid && !pop_fire) begin
          if (full) begin
            out_drop_valid <= 1'b1;
            out_drop_addr  <= beat[DEPTH-1] ?
                              slot[DEPTH-1][ADDR_W-1:0] :
                              in_ins_addr;
          end else begin
            count <= count + CNT_W'(1);
          end
        end else if (pop_fire && !in_ins_valid) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  assign out_head       = slot[0];
  assign out_count      = count;
  assign out_empty      = empty;
  assign out_full       = full;
  assign out_global_ovf = g_ovf;

endmodule

// File: tb/tb_pifo_calendar_queue.sv
// Directed bench for pifo_calendar_queue at DEPTH=4.
// Hand-computed expectations, one checking task.
module tb_pifo_calendar_queue;
  import pifo_calendar_pkg::*;

  localparam int DEPTH  = 4;
  localparam int RANK_W = 18;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 3;
  localparam int W      = 2 + RANK_W + ADDR_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_flush;
  logic              in_ins_valid;
  logic              in_ins_ovf;
  logic [RANK_W-1:0] in_ins_rank;
  logic [ADDR_W-1:0] in_ins_addr;
  logic              in_pop;
  logic              out_pop_valid;
  logic              out_pop_ovf;
  logic [RANK_W-1:0] out_pop_rank;
  logic [ADDR_W-1:0] out_pop_addr;
  logic              out_drop_valid;
  logic [ADDR_W-1:0] out_drop_addr;
  logic [W-1:0]      out_head;
  logic [CNT_W-1:0]  out_count;
  logic              out_empty;
  logic              out_full;
  logic              out_global_ovf;

  pifo_elem_t head;
  assign head = pifo_elem_t'(out_head);

  int n_chk  = 0;
  int n_pass = 0;

  pifo_calendar_queue #(
    .DEPTH  (DEPTH),
    .RANK_W (RANK_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_flush       (in_flush),
    .in_ins_valid   (in_ins_valid),
    .in_ins_ovf     (in_ins_ovf),
    .in_ins_rank    (in_ins_rank),
    .in_ins_addr    (in_ins_addr),
    .in_pop         (in_pop),
    .out_pop_valid  (out_pop_valid),
    .out_pop_ovf    (out_pop_ovf),
    .out_pop_rank   (out_pop_rank),
    .out_pop_addr   (out_pop_addr),
    .out_drop_valid (out_drop_valid),
    .out_drop_addr  (out_drop_addr),
    .out_head       (out_head),
    .out_count      (out_count),
    .out_empty      (out_empty),
    .out_full       (out_full),
    .out_global_ovf (out_global_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_in();
    in_flush     = 1'b0;
    in_ins_valid = 1'b0;
    in_ins_ovf   = 1'b0;
    in_ins_rank  = '0;
    in_ins_addr  = '0;
    in_pop       = 1'b0;
  endtask

  task automatic step(input logic ins, input logic ovf,
                      input int rank, input int addr,
                      input logic pop, input logic flush);
    in_ins_valid = ins;
    in_ins_ovf   = ovf;
    in_ins_rank  = RANK_W'(rank);
    in_ins_addr  = ADDR_W'(addr);
    in_pop       = pop;
    in_flush     = flush;
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic ins(input logic ovf, input int rank, input int addr);
    step(1'b1, ovf, rank, addr, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input int rank, input int addr);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    check({tag, "_v"}, 64'(out_pop_valid), 64'd1);
    check({tag, "_r"}, 64'(out_pop_rank), 64'(rank));
    check({tag, "_a"}, 64'(out_pop_addr), 64'(addr));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_empty", 64'(out_empty), 64'd1);
    check("rst_full", 64'(out_full), 64'd0);
    check("rst_head", 64'(out_head), 64'd0);
    check("rst_popv", 64'(out_pop_valid), 64'd0);
    check("rst_dropv", 64'(out_drop_valid), 64'd0);
    check("rst_govf", 64'(out_global_ovf), 64'd0);
    rstn = 1'b1;

    // sort + FIFO tie order
    ins(0, 50, 1);
    check("t1_lat_cnt", 64'(out_count), 64'd1);
    check("t1_lat_head", 64'(head.rank), 64'd50);
    ins(0, 20, 2);
    ins(0, 80, 3);
    ins(0, 20, 7);
    check("t1_count", 64'(out_count), 64'd4);
    check("t1_full", 64'(out_full), 64'd1);
    check("t1_head_r", 64'(head.rank), 64'd20);
    check("t1_head_a", 64'(head.addr), 64'd2);
    pop_chk("t1_p0", 20, 2);
    pop_chk("t1_p1", 20, 7);
    pop_chk("t1_p2", 50, 1);
    check("t1_not_empty", 64'(out_empty), 64'd0);
    pop_chk("t1_p3", 80, 3);
    check("t1_empty", 64'(out_empty), 64'd1);
    check("t1_govf", 64'(out_global_ovf), 64'd0);

    // full-queue drops
    ins(0, 10, 10);
    ins(0, 20, 20);
    ins(0, 30, 30);
    ins(0, 40, 40);
    ins(0, 25, 25);
    check("t2_drop_v", 64'(out_drop_valid), 64'd1);
    check("t2_drop_a", 64'(out_drop_addr), 64'd40);
    check("t2_count", 64'(out_count), 64'd4);
    ins(0, 90, 90);
    check("t2_drop2_v", 64'(out_drop_valid), 64'd1);
    check("t2_drop2_a", 64'(out_drop_addr), 64'd90);
    check("t2_head", 64'(head.rank), 64'd10);
    step(0, 0, 0, 0, 0, 0);
    check("t2_drop_pulse", 64'(out_drop_valid), 64'd0);
    pop_chk("t2_p0", 10, 10);
    pop_chk("t2_p1", 20, 20);
    pop_chk("t2_p2", 25, 25);
    pop_chk("t2_p3", 30, 30);

    // epoch wrap
    check("t3_govf0", 64'(out_global_ovf), 64'd0);
    ins(1, 5, 5);
    ins(0, 900, 9);
    check("t3_head", 64'(head.rank), 64'd900);
    pop_chk("t3_p0", 900, 9);
    check("t3_govf_keep", 64'(out_global_ovf), 64'd0);
    pop_chk("t3_p1", 5, 5);
    check("t3_pop_ovf", 64'(out_pop_ovf), 64'd1);
    check("t3_govf1", 64'(out_global_ovf), 64'd1);

    // insert+pop on a full queue
    ins(0, 10, 10);
    ins(0, 20, 20);
    ins(0, 30, 30);
    ins(0, 40, 40);
    step(1, 0, 15, 15, 1, 0);
    check("t4_popv", 64'(out_pop_valid), 64'd1);
    check("t4_pop_r", 64'(out_pop_rank), 64'd10);
    check("t4_dropv", 64'(out_drop_valid), 64'd0);
    check("t4_count", 64'(out_count), 64'd4);
    check("t4_head", 64'(head.rank), 64'd15);
    step(1, 0, 5, 5, 1, 0);
    check("t4_pop2_r", 64'(out_pop_rank), 64'd15);
    check("t4_head2", 64'(head.rank), 64'd5);
    check("t4_head2_a", 64'(head.addr), 64'd5);

    // flush with a concurrent insert on a 3-entry queue
    pop_chk("t6_p0", 5, 5);
    check("t6_count3", 64'(out_count), 64'd3);
    check("t6_head", 64'(head.rank), 64'd20);
    step(1, 0, 1, 1, 0, 1);
    check("t6_count", 64'(out_count), 64'd0);
    check("t6_empty", 64'(out_empty), 64'd1);
    check("t6_popv", 64'(out_pop_valid), 64'd0);
    check("t6_dropv", 64'(out_drop_valid), 64'd0);
    check("t6_head_v", 64'(out_head[VALID_POS]), 64'd0);
    check("t6_govf", 64'(out_global_ovf), 64'd0);

    // empty pop, empty insert+pop
    step(0, 0, 0, 0, 1, 0);
    check("t5_popv", 64'(out_pop_valid), 64'd0);
    check("t5_govf", 64'(out_global_ovf), 64'd0);
    step(1, 0, 7, 7, 1, 0);
    check("t5_ip_popv", 64'(out_pop_valid), 64'd0);
    check("t5_head", 64'(head.rank), 64'd7);
    check("t5_count", 64'(out_count), 64'd1);

    // reset mid-stream suppresses the pending pop
    ins(0, 3, 3);
    check("t7_count", 64'(out_count), 64'd2);
    in_pop = 1'b1;
    rstn   = 1'b0;
    @(posedge clk);
    #1;
    clear_in();
    check("t7_popv", 64'(out_pop_valid), 64'd0);
    check("t7_count", 64'(out_count), 64'd0);
    check("t7_empty", 64'(out_empty), 64'd1);
    check("t7_head", 64'(out_head), 64'd0);
    check("t7_govf", 64'(out_global_ovf), 64'd0);
    rstn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
